updown_sweep_ctrl: RTL

Sequencer that drives a W-bit up/down counter (enable/direction/load) to run programmable ping-pong sweeps between a low and a high bound, with a dwell at each end. Sits beside the updown4-style counter. Monitors the counter output and issues per-cycle control. Reports busy, done, abort and configuration-error status to the host logic.

---
 rtl/updown_sweep_pkg.sv | 21 ++
 rtl/sweep_dwell_timer.sv | 35 +++
 rtl/updown_sweep_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg
//   Shared definitions for the up/down sweep controller:
//   - default widths for counter/bounds (W), dwell count (DW), sweep count (SW)
//   - binary-encoded sequencer state type
package updown_sweep_pkg;

   localparam int unsigned W_DEF  = 4;
   localparam int unsigned DW_DEF = 4;
   localparam int unsigned SW_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_UP       = 3'd2,
      S_DWELL_HI = 3'd3,
      S_DOWN     = 3'd4,
      S_DWELL_LO = 3'd5,
      S_DONE     = 3'd6
   } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer
//   DW-bit down-counter used to time the hold at either sweep bound.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-low reset (clears the count)
//     load     in   load load_val (priority over dec)
//     load_val in   DW  value to load
//     dec      in   decrement by one, saturating at zero
//     zero     out  count is zero
module sweep_dwell_timer #(
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [DW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - DW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
//   Sequencer driving an external W-bit up/down counter through ping-pong
//   sweeps lo->hi->lo, holding dwell+1 cycles at each bound between sweeps.
//   Ports:
//     clk, rst            rising-edge clock, asynchronous active-low reset
//     start, abort        run request (IDLE only) / run termination (non-IDLE)
//     lo, hi, dwell,
//     n_sweeps            run configuration, latched on accepted start
//     q_in                registered counter value
//     cnt_en, cnt_dir,
//     cnt_load,
//     cnt_load_val        counter controls (load value is the latched lo)
//     busy, done,
//     aborted, cfg_err    status: not idle / normal end / abort taken / start rejected
//     sweep_cnt           completed sweeps in the current or last run
module updown_sweep_ctrl
   import updown_sweep_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned SW = SW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  lo,
   input  logic [W-1:0]  hi,
   input  logic [DW-1:0] dwell,
   input  logic [SW-1:0] n_sweeps,
   input  logic [W-1:0]  q_in,
   output logic          cnt_en,
   output logic          cnt_dir,
   output logic          cnt_load,
   output logic [W-1:0]  cnt_load_val,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          cfg_err,
   output logic [SW-1:0] sweep_cnt
);

   state_t        state, nxt;
   logic [W-1:0]  lo_l, hi_l;
   logic [DW-1:0] dwell_l;
   logic [SW-1:0] n_l;
   logic [SW-1:0] sweep_nxt;
   logic          cfg_bad, accept, take_abort;
   logic          at_hi, at_lo;
   logic          timer_load, timer_dec, dwell_zero;

   assign cfg_bad    = (lo >= hi) || (n_sweeps == '0);
   assign accept     = (state == S_IDLE) && start && !cfg_bad;
   assign take_abort = abort && (state != S_IDLE);
   assign at_hi      = (q_in == hi_l);
   assign at_lo      = (q_in == lo_l);
   assign sweep_nxt  = sweep_cnt + SW'(1);

   always_comb begin
      nxt        = state;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      unique case (state)
         S_IDLE:     if (accept) nxt = S_LOAD;
         S_LOAD:     nxt = S_UP;
         S_UP: begin
            if (at_hi) begin
               timer_load = 1'b1;
               nxt        = S_DWELL_HI;
            end
         end
         S_DWELL_HI: begin
            if (dwell_zero) nxt = S_DOWN;
            else            timer_dec = 1'b1;
         end
         S_DOWN: begin
            if (at_lo) begin
               if (sweep_nxt == n_l) begin
                  nxt = S_DONE;
               end else begin
                  timer_load = 1'b1;
                  nxt        = S_DWELL_LO;
               end
            end
         end
         S_DWELL_LO: begin
            if (dwell_zero) nxt = S_UP;
            else            timer_dec = 1'b1;
         end
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
      // abort overrides every transition, including leaving DONE normally
      if (take_abort) begin
         nxt        = S_IDLE;
         timer_load = 1'b0;
         timer_dec  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         lo_l      <= '0;
         hi_l      <= '0;
         dwell_l   <= '0;
         n_l       <= '0;
         sweep_cnt <= '0;
         cnt_dir   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state   <= nxt;
         cfg_err <= (state == S_IDLE) && start && cfg_bad;
         if (accept) begin
            lo_l      <= lo;
            hi_l      <= hi;
            dwell_l   <= dwell;
            n_l       <= n_sweeps;
            sweep_cnt <= '0;
         end
         if ((state == S_DOWN) && at_lo && !take_abort) begin
            sweep_cnt <= sweep_nxt;
         end
         // direction only moves on entry to a counting phase; abort holds it
         if (nxt == S_UP && state != S_UP) begin
            cnt_dir <= 1'b1;
         end else if (nxt == S_DOWN && state != S_DOWN) begin
            cnt_dir <= 1'b0;
         end
      end
   end

   sweep_dwell_timer #(.DW(DW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (dwell_l),
      .dec      (timer_dec),
      .zero     (dwell_zero)
   );

   // enable is decoded from q_in so the counter halts exactly on the bound
   assign cnt_en = !take_abort &&
                   (((state == S_UP)   && !at_hi) ||
                    ((state == S_DOWN) && !at_lo));
   assign cnt_load     = (state == S_LOAD) && !take_abort;
   assign cnt_load_val = lo_l;
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE) && !take_abort;
   assign aborted      = take_abort;

endmodule
